// File: rtl/syscall_controller.sv
// syscall_controller: services MIPS syscalls (print int, print string, exit)
// for the pipelined CPU. It stalls the pipeline, walks null-terminated strings
// through a memory read port and emits items on a valid/ready stream.
// Optional macro SYSCALL_STATS_EN enables the retired-instruction and cycle
// counters; when it is undefined both counters read constant 0.
module syscall_controller #(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sys_req,
    input  logic [31:0] sys_v,
    input  logic [31:0] sys_a,
    input  logic        inst_retire,
    output logic        stall,
    output logic        mem_rd,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_type,
    output logic [31:0] out_data,
    output logic        halt,
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count
);

    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, INT_OUT, STR_RD, STR_WAIT, STR_EMIT, NL_OUT, DONE, HALTED
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    a_q;
    logic [29:0]    ptr;
    logic [WCW-1:0] wcnt;
    logic [31:0]    word_buf;
    logic [1:0]     idx;
    logic [7:0]     cur_byte;
    logic           accept;
    logic           exit_req;

    assign cur_byte = word_buf[8*idx +: 8];
    assign accept   = (state == IDLE) && sys_req;
    assign exit_req = accept && (sys_v == 32'd10);
    assign mem_addr = ptr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; stream states only advance on out_ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sys_req) begin
                    case (sys_v)
                        32'd1:   state_nxt = INT_OUT;
                        32'd4:   state_nxt = STR_RD;
                        32'd10:  state_nxt = HALTED;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            INT_OUT:  if (out_ready) state_nxt = NL_OUT;
            STR_RD:   state_nxt = STR_WAIT;
            STR_WAIT: state_nxt = STR_EMIT;
            STR_EMIT: begin
                if (cur_byte == 8'h00)
                    state_nxt = NL_OUT;
                else if (out_ready && idx == 2'd3)
                    state_nxt = (wcnt == LAST_WORD) ? NL_OUT : STR_RD;
            end
            NL_OUT:   if (out_ready) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            HALTED:   state_nxt = HALTED;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: argument latch, string pointer, word buffer and byte index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            ptr      <= '0;
            wcnt     <= '0;
            word_buf <= '0;
            idx      <= '0;
        end else begin
            if (accept) begin
                a_q  <= sys_a;
                ptr  <= sys_a[31:2];
                wcnt <= '0;
            end
            if (state == STR_WAIT) begin
                word_buf <= mem_data;
                idx      <= '0;
            end
            if (state == STR_EMIT && cur_byte != 8'h00 && out_ready) begin
                if (idx != 2'd3) begin
                    idx <= idx + 2'd1;
                end else begin
                    ptr  <= ptr + 30'd1;
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    // Outputs; reset gates stall so it drops asynchronously even with sys_req held
    always_comb begin
        stall     = 1'b1;
        mem_rd    = 1'b0;
        out_valid = 1'b0;
        out_type  = 1'b0;
        out_data  = '0;
        halt      = 1'b0;
        case (state)
            IDLE:     stall = sys_req;
            INT_OUT: begin
                out_valid = 1'b1;
                out_type  = 1'b1;
                out_data  = a_q;
            end
            STR_RD:   mem_rd = 1'b1;
            STR_EMIT: begin
                out_valid = (cur_byte != 8'h00);
                out_data  = (cur_byte != 8'h00) ? {24'h0, cur_byte} : 32'h0;
            end
            NL_OUT: begin
                out_valid = 1'b1;
                out_data  = 32'h0000_000A;
            end
            DONE:     stall = 1'b0;
            HALTED:   halt = 1'b1;
            default:  stall = 1'b1;
        endcase
        if (reset) stall = 1'b0;
    end

`ifdef SYSCALL_STATS_EN
    logic count_en;
    // The exit-accept cycle is not counted: counters freeze from that cycle on
    assign count_en = (state != HALTED) && !exit_req;

    // Free-running statistics counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            inst_count  <= '0;
        end else if (count_en) begin
            cycle_count <= cycle_count + 32'd1;
            if (inst_retire) inst_count <= inst_count + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, inst_retire, exit_req};
    assign cycle_count  = '0;
    assign inst_count   = '0;
`endif

endmodule

// File: tb/tb_syscall_controller.sv
// Directed self-checking bench for syscall_controller (MAX_WORDS = 2 so the
// string walk limit is reachable with a short memory image).
module tb_syscall_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sys_req = 1'b0;
    logic [31:0] sys_v = '0;
    logic [31:0] sys_a = '0;
    logic        inst_retire = 1'b0;
    logic        stall, mem_rd, out_valid, out_type, halt;
    logic [29:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        out_ready = 1'b1;
    logic [31:0] out_data, inst_count, cycle_count;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;

    syscall_controller #(.MAX_WORDS(2)) dut (
        .clk(clk), .reset(reset), .sys_req(sys_req), .sys_v(sys_v), .sys_a(sys_a),
        .inst_retire(inst_retire), .stall(stall), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_data(out_data), .halt(halt),
        .inst_count(inst_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'h0010_0000: return 32'h0021_6948;   // "Hi!"
            30'h0020_0000: return 32'h4443_4241;   // "ABCD"
            30'h0020_0001: return 32'h4847_4645;   // "EFGH"
            30'h0020_0002: return 32'h4C4B_4A49;   // "IJKL"
            default:       return 32'h0;
        endcase
    endfunction

    // Memory with one-cycle read latency, plus a read counter
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem_word(mem_addr);
            rd_cnt   <= rd_cnt + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        step; step;
        #1;
        checks++;
        if ({stall, mem_rd, out_valid, out_type, halt, out_data, mem_addr, inst_count, cycle_count} !== '0) begin
            failures++;
            $display("FAIL reset_values got stall=%b rd=%b v=%b t=%b h=%b d=%h a=%h ic=%0d cc=%0d required all zero",
                     stall, mem_rd, out_valid, out_type, halt, out_data, mem_addr, inst_count, cycle_count);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_print_int;
        sys_req = 1'b1; sys_v = 32'd1; sys_a = 32'd42; out_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL int_accept_stall got=%b exp=1", stall); end
        step; #1;
        checks++;
        if ({out_valid, out_type, out_data} !== {1'b1, 1'b1, 32'd42}) begin
            failures++; $display("FAIL int_item got v=%b t=%b d=%0d exp v=1 t=1 d=42", out_valid, out_type, out_data);
        end
        step; #1;
        checks++;
        if ({out_valid, out_type, out_data} !== {1'b1, 1'b0, 32'h0A}) begin
            failures++; $display("FAIL int_newline got v=%b t=%b d=%h exp v=1 t=0 d=0a", out_valid, out_type, out_data);
        end
        step; #1;
        checks++;
        if ({stall, out_valid} !== 2'b00) begin
            failures++; $display("FAIL int_done got stall=%b v=%b exp 0 0", stall, out_valid);
        end
        sys_req = 1'b0;
        // T+4 must be IDLE: a new request raises stall combinationally there
        step;
        sys_req = 1'b1; sys_v = 32'd0;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL int_idle_t4 got stall=%b exp=1", stall); end
        step;
        sys_req = 1'b0;
        step;
    endtask

    task automatic test_unknown;
        sys_req = 1'b1; sys_v = 32'd5; sys_a = 32'h0040_0000;
        #1;
        checks++;
        if ({stall, out_valid, mem_rd} !== 3'b100) begin
            failures++; $display("FAIL unk_accept got stall=%b v=%b rd=%b exp 1 0 0", stall, out_valid, mem_rd);
        end
        step; #1;
        checks++;
        if ({stall, out_valid, mem_rd} !== 3'b000) begin
            failures++; $display("FAIL unk_done got stall=%b v=%b rd=%b exp 0 0 0", stall, out_valid, mem_rd);
        end
        sys_req = 1'b0;
        step; #1;
        checks++;
        if ({stall, out_valid, halt} !== 3'b000) begin
            failures++; $display("FAIL unk_idle got stall=%b v=%b h=%b exp 0 0 0", stall, out_valid, halt);
        end
    endtask

    task automatic test_print_string;
        int es [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int er [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        int ev [8] = '{0, 0, 1, 1, 1, 0, 1, 0};
        int ed [8] = '{0, 0, 'h48, 'h69, 'h21, 0, 'h0A, 0};
        int rd0 = rd_cnt;
        logic [35:0] obs, exp;
        sys_req = 1'b1; sys_v = 32'd4; sys_a = 32'h0040_0000; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step; #1;
            obs = {stall, mem_rd, out_valid, out_valid & out_type, out_valid ? out_data : 32'h0};
            exp = {es[k][0], er[k][0], ev[k][0], 1'b0, 32'(ed[k])};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL str_cycle T+%0d got=%h exp=%h", k + 1, obs, exp); end
            if (er[k] != 0) begin
                checks++;
                if (mem_addr !== 30'h0010_0000) begin
                    failures++; $display("FAIL str_addr got=%h exp=00100000", mem_addr);
                end
            end
            if (es[k] == 0) sys_req = 1'b0;
        end
        step;
        checks++;
        if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL str_reads got=%0d exp=1", rd_cnt - rd0); end
    endtask

    task automatic test_backpressure;
        int es  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int ev  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 0};
        int ed  [11] = '{0, 0, 'h48, 'h69, 'h69, 'h69, 'h69, 'h21, 0, 'h0A, 0};
        int rdy [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        int rd0 = rd_cnt;
        logic [34:0] obs, exp;
        sys_req = 1'b1; sys_v = 32'd4; sys_a = 32'h0040_0000; out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            step;
            out_ready = rdy[k][0];
            #1;
            obs = {stall, out_valid, out_valid & out_type, out_valid ? out_data : 32'h0};
            exp = {es[k][0], ev[k][0], 1'b0, 32'(ed[k])};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL bp_cycle T+%0d got=%h exp=%h", k + 1, obs, exp); end
            if (es[k] == 0) sys_req = 1'b0;
        end
        out_ready = 1'b1;
        step;
        checks++;
        if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL bp_reads got=%0d exp=1", rd_cnt - rd0); end
    endtask

    task automatic test_limit;
        int es [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int er [14] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        int ev [14] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        int ed [14] = '{0, 0, 'h41, 'h42, 'h43, 'h44, 0, 0, 'h45, 'h46, 'h47, 'h48, 'h0A, 0};
        logic [29:0] ea [14] = '{30'h0020_0000, 0, 0, 0, 0, 0, 30'h0020_0001, 0, 0, 0, 0, 0, 0, 0};
        int rd0 = rd_cnt;
        logic [35:0] obs, exp;
        sys_req = 1'b1; sys_v = 32'd4; sys_a = 32'h0080_0000; out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step; #1;
            obs = {stall, mem_rd, out_valid, out_valid & out_type, out_valid ? out_data : 32'h0};
            exp = {es[k][0], er[k][0], ev[k][0], 1'b0, 32'(ed[k])};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL lim_cycle T+%0d got=%h exp=%h", k + 1, obs, exp); end
            if (er[k] != 0) begin
                checks++;
                if (mem_addr !== ea[k]) begin
                    failures++; $display("FAIL lim_addr T+%0d got=%h exp=%h", k + 1, mem_addr, ea[k]);
                end
            end
            if (es[k] == 0) sys_req = 1'b0;
        end
        step;
        checks++;
        if (rd_cnt - rd0 != 2) begin failures++; $display("FAIL lim_reads got=%0d exp=2", rd_cnt - rd0); end
    endtask

    task automatic test_reset_mid_string;
        sys_req = 1'b1; sys_v = 32'd4; sys_a = 32'h0040_0000; out_ready = 1'b1;
        step; step; step; #1;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h48}) begin
            failures++; $display("FAIL rst_pre got v=%b d=%h exp v=1 d=48", out_valid, out_data);
        end
        #2;                      // mid-cycle, away from any clock edge
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, stall, mem_rd, halt} !== 4'b0000) begin
            failures++; $display("FAIL rst_async got v=%b stall=%b rd=%b h=%b exp all 0", out_valid, stall, mem_rd, halt);
        end
        sys_req = 1'b0;
        step;
        reset = 1'b0;
        step;
        sys_req = 1'b1; sys_v = 32'd1; sys_a = 32'd7;
        step; #1;
        checks++;
        if ({out_valid, out_type, out_data} !== {1'b1, 1'b1, 32'd7}) begin
            failures++; $display("FAIL rst_int_item got v=%b t=%b d=%0d exp v=1 t=1 d=7", out_valid, out_type, out_data);
        end
        step; #1;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h0A}) begin
            failures++; $display("FAIL rst_int_nl got v=%b d=%h exp v=1 d=0a", out_valid, out_data);
        end
        step; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL rst_int_done got stall=%b exp=0", stall); end
        sys_req = 1'b0;
        step;
    endtask

    task automatic test_exit;
        logic [31:0] exp_cc, exp_ic;
`ifdef SYSCALL_STATS_EN
        exp_cc = 32'd100; exp_ic = 32'd37;
`else
        exp_cc = 32'd0;   exp_ic = 32'd0;
`endif
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i < 37);
            step;
        end
        inst_retire = 1'b1;      // retire in the exit cycle must not count
        sys_req = 1'b1; sys_v = 32'd10; sys_a = 32'd0;
        #1;
        checks++;
        if (halt !== 1'b0) begin failures++; $display("FAIL exit_pre_halt got=%b exp=0", halt); end
        step; #1;
        checks++;
        if ({halt, stall} !== 2'b11) begin
            failures++; $display("FAIL exit_halt got h=%b stall=%b exp 1 1", halt, stall);
        end
        checks++;
        if ({cycle_count, inst_count} !== {exp_cc, exp_ic}) begin
            failures++; $display("FAIL exit_counts got cc=%0d ic=%0d exp cc=%0d ic=%0d", cycle_count, inst_count, exp_cc, exp_ic);
        end
        sys_req = 1'b0;
        for (int i = 0; i < 5; i++) step;
        #1;
        checks++;
        if ({halt, stall, out_valid} !== 3'b110) begin
            failures++; $display("FAIL exit_sticky got h=%b stall=%b v=%b exp 1 1 0", halt, stall, out_valid);
        end
        checks++;
        if ({cycle_count, inst_count} !== {exp_cc, exp_ic}) begin
            failures++; $display("FAIL exit_frozen got cc=%0d ic=%0d exp cc=%0d ic=%0d", cycle_count, inst_count, exp_cc, exp_ic);
        end
        inst_retire = 1'b0;
    endtask

    initial begin
        test_reset;
        test_print_int;
        test_unknown;
        test_print_string;
        test_backpressure;
        test_limit;
        test_reset_mid_string;
        test_exit;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
